// File: rtl/gcd_host.sv
// gcd_host: accepts operand pairs, sequences an external GCD engine
// (reset, load A, load B, wait for done) or short-circuits zero operands,
// then presents one result at a time on a valid/ready port.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   op_valid/op_ready/op_a/op_b   operand pair handshake (16-bit operands)
//   res_valid/res_ready           result handshake
//   res_gcd/res_err               result value and error flag
//   jobs_done                     saturating count of accepted results
//   eng_rst/eng_start/eng_data    drive to the GCD engine
//   eng_done/eng_result           returned by the GCD engine
module gcd_host #(
    parameter int TIMEOUT = 70000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_gcd,
    output logic        res_err,
    output logic [15:0] jobs_done,
    output logic        eng_rst,
    output logic        eng_start,
    output logic [15:0] eng_data,
    input  logic        eng_done,
    input  logic [15:0] eng_result
);

    // Counter holds 0..TIMEOUT-1; never narrower than 17 bits.
    localparam int CW = ($clog2(TIMEOUT) > 17) ? $clog2(TIMEOUT) : 17;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ENG,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   gcd_q, gcd_d;
    logic          err_q, err_d;
    logic [15:0]   jobs_q, jobs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        jobs_d  = jobs_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d = op_a;
                    b_d = op_b;
                    if ((op_a != 16'd0) && (op_b != 16'd0)) begin
                        state_d = S_RST_ENG;
                    end else if ((op_a == 16'd0) && (op_b == 16'd0)) begin
                        state_d = S_HOLD;
                        gcd_d   = 16'd0;
                        err_d   = 1'b1;
                    end else begin
                        // One operand is zero: the other one is the GCD.
                        state_d = S_HOLD;
                        gcd_d   = op_a | op_b;
                        err_d   = 1'b0;
                    end
                end
            end
            S_RST_ENG: state_d = S_LOAD_A;
            S_LOAD_A:  state_d = S_LOAD_B;
            S_LOAD_B: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Done takes priority over a coincident timeout.
                if (eng_done) begin
                    state_d = S_HOLD;
                    gcd_d   = eng_result;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HOLD;
                    gcd_d   = 16'd0;
                    err_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    if (jobs_q != 16'hFFFF) begin
                        jobs_d = jobs_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == S_IDLE);
        res_valid = (state_q == S_HOLD);
        res_gcd   = gcd_q;
        res_err   = err_q;
        jobs_done = jobs_q;
        eng_rst   = (state_q == S_RST_ENG);
        eng_start = (state_q == S_LOAD_A);
        eng_data  = 16'd0;
        if (state_q == S_LOAD_A) begin
            eng_data = a_q;
        end else if (state_q == S_LOAD_B) begin
            eng_data = b_q;
        end
    end

endmodule

// File: tb/tb_gcd_host.sv
// tb_gcd_host: directed, table-driven bench for gcd_host with a small
// behavioural GCD engine model attached to the engine pins.
module tb_gcd_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_gcd;
    logic        res_err;
    logic [15:0] jobs_done;
    logic        eng_rst;
    logic        eng_start;
    logic [15:0] eng_data;
    logic        eng_done;
    logic [15:0] eng_result;

    always #5 clk = ~clk;

    gcd_host #(.TIMEOUT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_gcd    (res_gcd),
        .res_err    (res_err),
        .jobs_done  (jobs_done),
        .eng_rst    (eng_rst),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    // Engine model: latch A on start, B on the following cycle, then
    // raise done on WAIT cycle number done_at (when done_en is set).
    logic [1:0]  phase;
    int          wcnt;
    logic [15:0] ea, eb;
    logic        done_en = 1'b1;
    int          done_at = 5;

    function automatic logic [15:0] gcd_f(input logic [15:0] x,
                                          input logic [15:0] y);
        logic [15:0] p, q, t;
        p = x;
        q = y;
        while (q != 16'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
            wcnt  <= 0;
            ea    <= '0;
            eb    <= '0;
        end else if (eng_rst) begin
            phase <= 2'd0;
            wcnt  <= 0;
        end else if (eng_start) begin
            ea    <= eng_data;
            phase <= 2'd1;
        end else if (phase == 2'd1) begin
            eb    <= eng_data;
            phase <= 2'd2;
            wcnt  <= 0;
        end else if (phase == 2'd2) begin
            wcnt <= wcnt + 1;
        end
    end

    assign eng_done   = done_en && (phase == 2'd2) && (wcnt == done_at - 1);
    assign eng_result = gcd_f(ea, eb);

    // Watches engine pins during bypass jobs.
    logic mon = 1'b0;
    logic eng_seen = 1'b0;
    always @(negedge clk) begin
        if (mon && (eng_rst || eng_start)) eng_seen = 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_jobs = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        err;
        logic        eng;
    } vec_t;

    task automatic run_job(input vec_t v, input int exp_wait,
                           input int hold_cycles);
        int k;
        op_a     = v.a;
        op_b     = v.b;
        op_valid = 1'b1;
        check("op_ready_idle", op_ready, 1);
        eng_seen = 1'b0;
        mon      = 1'b1;
        tick();
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        if (v.eng) begin
            check("rst_eng_pulse", eng_rst, 1);
            check("rst_eng_start", eng_start, 0);
            check("rst_eng_data", eng_data, 0);
            check("busy_op_ready", op_ready, 0);
            check("busy_res_valid", res_valid, 0);
            tick();
            check("load_a_rst", eng_rst, 0);
            check("load_a_start", eng_start, 1);
            check("load_a_data", eng_data, v.a);
            tick();
            check("load_b_start", eng_start, 0);
            check("load_b_data", eng_data, v.b);
            tick();
            k = 0;
            while (!res_valid && k < 400) begin
                k++;
                tick();
            end
            check("wait_cycles", k, exp_wait);
        end else begin
            check("bypass_next_cycle", res_valid, 1);
        end
        check("res_gcd", res_gcd, v.g);
        check("res_err", res_err, v.err);
        check("hold_op_ready", op_ready, 0);
        for (int i = 0; i < hold_cycles; i++) begin
            op_valid = 1'b1;
            op_a     = 16'd5;
            op_b     = 16'd10;
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_gcd", res_gcd, v.g);
            check("hold_err", res_err, v.err);
            check("hold_op_ready", op_ready, 0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        check("jobs_before_ack", jobs_done, exp_jobs);
        tick();
        res_ready = 1'b0;
        exp_jobs++;
        mon = 1'b0;
        if (!v.eng) check("bypass_eng_quiet", eng_seen, 0);
        check("jobs_after_ack", jobs_done, exp_jobs);
        check("idle_res_valid", res_valid, 0);
        check("idle_op_ready", op_ready, 1);
    endtask

    vec_t vecs[8];
    vec_t tmp;

    initial begin
        vecs[0] = '{a: 16'd48,    b: 16'd18,    g: 16'd6,     err: 1'b0, eng: 1'b1};
        vecs[1] = '{a: 16'd0,     b: 16'd9,     g: 16'd9,     err: 1'b0, eng: 1'b0};
        vecs[2] = '{a: 16'd0,     b: 16'd0,     g: 16'd0,     err: 1'b1, eng: 1'b0};
        vecs[3] = '{a: 16'd21,    b: 16'd0,     g: 16'd21,    err: 1'b0, eng: 1'b0};
        vecs[4] = '{a: 16'd17,    b: 16'd5,     g: 16'd1,     err: 1'b0, eng: 1'b1};
        vecs[5] = '{a: 16'd65535, b: 16'd65535, g: 16'd65535, err: 1'b0, eng: 1'b1};
        vecs[6] = '{a: 16'd1024,  b: 16'd96,    g: 16'd32,    err: 1'b0, eng: 1'b1};
        vecs[7] = '{a: 16'd1,     b: 16'd1,     g: 16'd1,     err: 1'b0, eng: 1'b1};

        #2;
        check("rst_op_ready", op_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_gcd", res_gcd, 0);
        check("rst_res_err", res_err, 0);
        check("rst_jobs", jobs_done, 0);
        check("rst_eng_rst", eng_rst, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_data", eng_data, 0);
        tick();
        rst = 1'b0;
        tick();

        done_en = 1'b1;
        done_at = 5;
        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i], 5, 0);
        end

        // Engine never finishes: timeout after 100 WAIT cycles, then a
        // long stall on the result port with op_valid pounding.
        done_en = 1'b0;
        tmp = '{a: 16'd7, b: 16'd3, g: 16'd0, err: 1'b1, eng: 1'b1};
        run_job(tmp, 100, 10);
        tick();
        check("no_stray_accept", op_ready, 1);

        // Reset in the middle of WAIT.
        done_en  = 1'b1;
        done_at  = 50;
        op_a     = 16'd48;
        op_b     = 16'd18;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_op_ready", op_ready, 1);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_gcd", res_gcd, 0);
        check("mid_rst_res_err", res_err, 0);
        check("mid_rst_jobs", jobs_done, 0);
        check("mid_rst_eng_rst", eng_rst, 0);
        check("mid_rst_eng_start", eng_start, 0);
        check("mid_rst_eng_data", eng_data, 0);
        repeat (2) tick();
        rst      = 1'b0;
        exp_jobs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_result", res_valid, 0);
        end
        done_at = 5;
        tmp = '{a: 16'd36, b: 16'd24, g: 16'd12, err: 1'b0, eng: 1'b1};
        run_job(tmp, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
